// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: packs the HPS download byte stream into 32-bit SDRAM
// word writes through a small FIFO, flushing any partial word at the end.
module ioctl_sdram_loader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [22:0] BASE_ADDR  = 23'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   input  logic        ioctl_download,
   output logic [22:0] sdram_addr,
   output logic [31:0] sdram_data,
   output logic        sdram_we,
   output logic        sdram_req,
   input  logic        sdram_ack,
   output logic        busy,
   output logic        done,
   output logic        overflow
);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

   state_t        state_q, state_d;
   logic          dl_q;
   logic [31:0]   asm_data_q, asm_data_d;
   logic [22:0]   asm_addr_q, asm_addr_d;
   logic          asm_vld_q, asm_vld_d;
   logic          asm_full_q, asm_full_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          req_q, req_d;
   logic [22:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic [54:0]   mem_q [FIFO_DEPTH];

   logic          rise, fall, byte_ok;
   logic [22:0]   byte_addr;
   logic          push, push_ok, pop;
   logic [54:0]   push_word;
   logic [AW:0]   remain;

   assign rise      = ioctl_download & ~dl_q;
   assign fall      = ~ioctl_download & dl_q;
   assign byte_ok   = ioctl_wr & ioctl_download;
   assign byte_addr = ioctl_addr[24:2] + BASE_ADDR;

   // asm_full marks a completed lane-3 word that lost the push slot to an
   // older partial word in the same cycle; it goes out on the next cycle.
   always_comb begin
      push       = 1'b0;
      push_word  = {asm_addr_q, asm_data_q};
      asm_data_d = asm_data_q;
      asm_addr_d = asm_addr_q;
      asm_vld_d  = asm_vld_q;
      asm_full_d = asm_full_q;
      if (rise) begin
         asm_data_d = '0;
         asm_addr_d = '0;
         asm_vld_d  = 1'b0;
         asm_full_d = 1'b0;
      end else if (!byte_ok && (asm_full_q || (fall && asm_vld_q))) begin
         push       = 1'b1;
         asm_data_d = '0;
         asm_addr_d = '0;
         asm_vld_d  = 1'b0;
         asm_full_d = 1'b0;
      end
      if (byte_ok) begin
         if (asm_full_d || (asm_vld_d && asm_addr_d != byte_addr)) begin
            push       = 1'b1;
            push_word  = {asm_addr_d, asm_data_d};
            asm_data_d = '0;
            asm_full_d = 1'b0;
         end
         asm_data_d[{ioctl_addr[1:0], 3'b000} +: 8] = ioctl_data;
         asm_addr_d = byte_addr;
         asm_vld_d  = 1'b1;
         if (ioctl_addr[1:0] == 2'd3) begin
            if (push) begin
               asm_full_d = 1'b1;
            end else begin
               push       = 1'b1;
               push_word  = {asm_addr_d, asm_data_d};
               asm_data_d = '0;
               asm_addr_d = '0;
               asm_vld_d  = 1'b0;
            end
         end
      end
   end

   always_comb begin
      pop      = req_q & sdram_ack;
      push_ok  = push & ((cnt_q != DEPTH) | pop);
      cnt_d    = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      remain   = cnt_q - {{AW{1'b0}}, pop};
      req_d    = req_q;
      addr_d   = addr_q;
      data_d   = data_q;
      ovf_d    = ovf_q;
      if (rise) ovf_d = 1'b0;
      if (push && !push_ok) ovf_d = 1'b1;
      // an empty FIFO forwards the incoming word straight to the port
      if (pop || !req_q) begin
         req_d = 1'b0;
         if (remain != '0) begin
            {addr_d, data_d} = mem_q[rd_ptr_d];
            req_d = 1'b1;
         end else if (push_ok) begin
            {addr_d, data_d} = push_word;
            req_d = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE:   if (rise) state_d = S_ACTIVE;
         S_ACTIVE: if (fall) state_d = S_FLUSH;
         S_FLUSH: begin
            if (rise) begin
               state_d = S_ACTIVE;
            end else if (cnt_d == '0 && !req_d) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         dl_q       <= 1'b0;
         asm_data_q <= '0;
         asm_addr_q <= '0;
         asm_vld_q  <= 1'b0;
         asm_full_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dl_q       <= ioctl_download;
         asm_data_q <= asm_data_d;
         asm_addr_q <= asm_addr_d;
         asm_vld_q  <= asm_vld_d;
         asm_full_q <= asm_full_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_word;
   end

   assign sdram_addr = addr_q;
   assign sdram_data = data_q;
   assign sdram_req  = req_q;
   assign sdram_we   = req_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign overflow   = ovf_q;
endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Scoreboard bench for ioctl_sdram_loader: directed cases plus random
// downloads checked against a byte-to-word reference model.
module tb_ioctl_sdram_loader;
   localparam int unsigned DEPTH = 4;
   localparam logic [22:0] BASE  = 23'h100000;

   logic        clk = 1'b0;
   logic        reset;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wr;
   logic        ioctl_download;
   logic [22:0] sdram_addr;
   logic [31:0] sdram_data;
   logic        sdram_we;
   logic        sdram_req;
   logic        sdram_ack;
   logic        busy;
   logic        done;
   logic        overflow;

   always #5 clk = ~clk;

   ioctl_sdram_loader #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
      .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
      .sdram_addr(sdram_addr), .sdram_data(sdram_data),
      .sdram_we(sdram_we), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
      .busy(busy), .done(done), .overflow(overflow)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int req_cycles = 0;
   logic [54:0] exp_q [$];

   bit ack_en    = 1'b0;
   bit force_ack = 1'b0;
   int lat_min   = 0;
   int lat_max   = 0;
   int wcnt      = 0;

   logic        p_req  = 1'b0;
   logic        p_ack  = 1'b0;
   logic        p_rst  = 1'b1;
   logic [22:0] p_addr = '0;
   logic [31:0] p_data = '0;

   logic        m_vld  = 1'b0;
   logic [22:0] m_wa   = '0;
   logic [31:0] m_data = '0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // controller model: acks each request after a random number of cycles
   initial begin
      sdram_ack = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (sdram_ack) begin
            sdram_ack = 1'b0;
            wcnt = $urandom_range(lat_max, lat_min);
         end else if (force_ack) begin
            sdram_ack = 1'b1;
         end else if (!sdram_req) begin
            wcnt = $urandom_range(lat_max, lat_min);
         end else if (ack_en) begin
            if (wcnt == 0) sdram_ack = 1'b1;
            else wcnt--;
         end
      end
   end

   // monitor: values seen here are those the DUT samples on the next edge
   initial begin
      logic [54:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (done) begin
            done_cnt++;
            check("busy_at_done", busy, 0);
         end
         if (sdram_req) begin
            req_cycles++;
            check("we_eq_req", sdram_we, 1);
         end
         if (p_req && !p_ack && !p_rst)
            check("req_hold", {sdram_req, sdram_addr, sdram_data},
                  {1'b1, p_addr, p_data});
         if (sdram_req && sdram_ack && !reset) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL write: got %h@%h, expected no write",
                        sdram_data, sdram_addr);
            end else begin
               e = exp_q.pop_front();
               check("write", {sdram_addr, sdram_data}, e);
            end
         end
         p_req  = sdram_req;
         p_ack  = sdram_ack;
         p_rst  = reset;
         p_addr = sdram_addr;
         p_data = sdram_data;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr   = 1'b0;
   endtask

   task automatic model_push();
      if (m_vld) exp_q.push_back({m_wa, m_data});
      m_vld  = 1'b0;
      m_data = '0;
   endtask

   task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
      logic [22:0] wa;
      int lane;
      wa   = a[24:2] + BASE;
      lane = int'(a[1:0]);
      if (m_vld && m_wa != wa) model_push();
      m_data[lane*8 +: 8] = d;
      m_wa  = wa;
      m_vld = 1'b1;
      if (lane == 3) model_push();
   endtask

   task automatic dl_rise();
      ioctl_download = 1'b1;
      m_vld  = 1'b0;
      m_data = '0;
      @(negedge clk);
   endtask

   task automatic dl_fall();
      ioctl_download = 1'b0;
      model_push();
      @(negedge clk);
   endtask

   task automatic wait_done(input string name);
      int start;
      start = done_cnt;
      for (int k = 0; k < 400; k++) begin
         if (done_cnt != start) break;
         @(negedge clk);
      end
      cyc(3);
      check(name, done_cnt - start, 1);
      check("busy_after_done", busy, 0);
      check("drain", exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [24:0] a;
      logic [24:0] region;
      logic [7:0]  d;
      int rc;
      int dc;
      int nb;
      int p;

      reset = 1'b1;
      ioctl_addr = '0;
      ioctl_data = '0;
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      cyc(3);
      reset = 1'b0;
      cyc(1);
      check("rst_req", sdram_req, 0);
      check("rst_we", sdram_we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", overflow, 0);
      check("rst_addr_data", {sdram_addr, sdram_data}, 0);

      // strobes and a stray ack without a download
      rc = req_cycles;
      dc = done_cnt;
      strobe(25'd3, 8'h55);
      strobe(25'd0, 8'h66);
      strobe(25'd7, 8'h77);
      force_ack = 1'b1;
      cyc(1);
      force_ack = 1'b0;
      cyc(5);
      check("nodl_busy", busy, 0);
      check("nodl_req", req_cycles - rc, 0);
      check("nodl_done", done_cnt - dc, 0);

      // one full word, ack latency 3
      lat_min = 3;
      lat_max = 3;
      ack_en  = 1'b1;
      dl_rise();
      check("t1_busy", busy, 1);
      exp_q.push_back({BASE, 32'h44332211});
      strobe(25'd0, 8'h11);
      strobe(25'd1, 8'h22);
      strobe(25'd2, 8'h33);
      strobe(25'd3, 8'h44);
      check("t1_req_latency", {sdram_req, sdram_addr, sdram_data},
            {1'b1, BASE, 32'h44332211});
      cyc(8);
      dl_fall();
      wait_done("t1_done_once");

      // six bytes: one full word and a flushed partial
      lat_min = 0;
      lat_max = 2;
      dl_rise();
      exp_q.push_back({BASE, 32'h04030201});
      exp_q.push_back({BASE + 23'd1, 32'h00000605});
      for (int i = 0; i < 6; i++) begin
         strobe(25'(i), 8'(i + 1));
         cyc(1);
      end
      dl_fall();
      wait_done("t2_done");

      // address jump pushes the partial word
      dl_rise();
      exp_q.push_back({BASE + 23'd2, 32'h000000AA});
      exp_q.push_back({BASE + 23'd8, 32'h000000BB});
      strobe(25'h8, 8'hAA);
      cyc(2);
      strobe(25'h20, 8'hBB);
      cyc(2);
      dl_fall();
      wait_done("t3_done");

      // controller stalled: the fifth word is dropped
      ack_en = 1'b0;
      dl_rise();
      for (int w = 0; w < 5; w++) begin
         if (w < 4)
            exp_q.push_back({BASE + 23'(w),
                             {8'(4*w + 8'h13), 8'(4*w + 8'h12),
                              8'(4*w + 8'h11), 8'(4*w + 8'h10)}});
      end
      for (int i = 0; i < 20; i++) begin
         strobe(25'(i), 8'(i + 8'h10));
         cyc(1);
      end
      check("ovf_set", overflow, 1);
      check("ovf_req", sdram_req, 1);
      lat_min = 0;
      lat_max = 0;
      ack_en  = 1'b1;
      cyc(20);
      check("ovf_sticky", overflow, 1);
      check("ovf_written", exp_q.size(), 0);
      dl_fall();
      wait_done("ovf_done");
      check("ovf_after_done", overflow, 1);
      dl_rise();
      check("ovf_clear_on_rise", overflow, 0);
      dl_fall();
      wait_done("ovf_empty_done");

      // reset with two words queued
      ack_en = 1'b0;
      dl_rise();
      for (int i = 0; i < 8; i++) begin
         strobe(25'(i + 64), 8'(i + 8'hC0));
         cyc(1);
      end
      check("rst_mid_req_before", sdram_req, 1);
      reset = 1'b1;
      ioctl_download = 1'b0;
      m_vld = 1'b0;
      m_data = '0;
      cyc(1);
      reset = 1'b0;
      check("rst_mid_req", sdram_req, 0);
      check("rst_mid_busy", busy, 0);
      rc = req_cycles;
      dc = done_cnt;
      ack_en = 1'b1;
      lat_max = 2;
      cyc(20);
      check("rst_mid_noreq", req_cycles - rc, 0);
      check("rst_mid_nodone", done_cnt - dc, 0);
      check("rst_mid_busy_after", busy, 0);

      // random downloads against the reference model
      for (int dl = 0; dl < 6; dl++) begin
         dl_rise();
         cyc(2);
         region = ($urandom_range(1, 0) == 1) ? 25'h1FFFFC0
                  : 25'($urandom_range(1023, 0)) << 6;
         a  = region + 25'($urandom_range(63, 0));
         nb = $urandom_range(30, 1);
         for (int b = 0; b < nb; b++) begin
            if (b > 0) begin
               p = $urandom_range(9, 0);
               if (p < 6) a = a + 25'd1;
               else if (p < 8) a = region + 25'($urandom_range(63, 0));
            end
            d = 8'($urandom_range(255, 0));
            strobe(a, d);
            model_byte(a, d);
            cyc($urandom_range(7, 4));
         end
         dl_fall();
         wait_done("rnd_done");
      end
      check("rnd_no_ovf", overflow, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
